// File: rtl/mont_encode_pipe_pkg.sv
// Shared Dilithium constants and datapath types.
// Exports Q, QINV, R2, MONT, N, coeff_t, prod_t and freeze().
package dilithium_pkg;

  localparam int Q     = 8380417;
  localparam int QINV  = 58728449;
  localparam int R2    = 2365951;
  localparam int MONT  = 4193792;
  localparam int N     = 256;
  localparam int WIDTH = 32;

  typedef logic signed [31:0] coeff_t;
  typedef logic signed [63:0] prod_t;

  // Map r in (-q, q) to canonical [0, q).
  function automatic coeff_t freeze(
    coeff_t r,
    coeff_t q
  );
    return r[31] ? r + q : r;
  endfunction

endpackage

// File: rtl/mont_encode_pipe_if.sv
// Valid/ready stream bundle for the Montgomery encoder.
// master drives in_*/out_ready; slave drives in_ready/out_*.
interface mont_encode_pipe_if #(
  parameter int WIDTH = 32
);

  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out_data;
  logic                    out_last;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_last
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_last
  );

endinterface

// File: rtl/mont_redc_stage.sv
// Two-register pipelined Montgomery reduction: r = p * 2^-32 mod q.
// Ports: clk, rst_n, en (advance), in_valid/in_p, out_valid/out_r, busy.
module mont_redc_stage
  import dilithium_pkg::*;
#(
  parameter int Q    = dilithium_pkg::Q,
  parameter int QINV = dilithium_pkg::QINV
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  input  logic   in_valid,
  input  prod_t  in_p,
  output logic   out_valid,
  output coeff_t out_r,
  output logic   busy
);

  logic        v2;
  prod_t       p2;
  coeff_t      t2;
  logic [31:0] t_c;
  prod_t       tq;

  // Only the low word matters: t = p * q^-1 mod 2^32.
  assign t_c = in_p[31:0] * 32'(QINV);

  assign tq = prod_t'(t2) * prod_t'(Q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2 <= 1'b0;
      p2 <= '0;
      t2 <= '0;
    end else if (en) begin
      v2 <= in_valid;
      p2 <= in_p;
      t2 <= coeff_t'(t_c);
    end
  end

  // p - t*q has a zero low word, so the shift is exact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_r     <= '0;
    end else if (en) begin
      out_valid <= v2;
      out_r     <= coeff_t'((p2 - tq) >>> 32);
    end
  end

  assign busy = v2 | out_valid;

endmodule

// File: rtl/mont_encode_pipe.sv
// Streaming x -> x*2^32 mod q encoder (multiply by R2, then REDC).
// Ports: clk, rst_n, bus (slave stream), busy. Macro: MONT_ENCODE_FREEZE_EN.
module mont_encode_pipe
  import dilithium_pkg::*;
#(
  parameter int Q     = dilithium_pkg::Q,
  parameter int QINV  = dilithium_pkg::QINV,
  parameter int R2    = dilithium_pkg::R2,
  parameter int N     = dilithium_pkg::N,
  parameter int WIDTH = dilithium_pkg::WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  mont_encode_pipe_if.slave  bus,
  output logic               busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic          adv;
  logic          v1;
  prod_t         p1;
  logic          v3;
  coeff_t        r3;
  logic          redc_busy;
  logic          ov;
  coeff_t        r_out;
  logic [IW-1:0] idx;
  coeff_t        x_in;

  // Whole pipe moves together; a stalled output freezes every stage.
  assign adv          = !ov || bus.out_ready;
  assign bus.in_ready = adv;

  assign x_in = coeff_t'(signed'(bus.in_data[WIDTH-1:0]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      p1 <= '0;
    end else if (adv) begin
      v1 <= bus.in_valid;
      p1 <= prod_t'(x_in) * prod_t'(R2);
    end
  end

  mont_redc_stage #(
    .Q    (Q),
    .QINV (QINV)
  ) u_redc (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (adv),
    .in_valid  (v1),
    .in_p      (p1),
    .out_valid (v3),
    .out_r     (r3),
    .busy      (redc_busy)
  );

`ifdef MONT_ENCODE_FREEZE_EN
  logic   v4;
  coeff_t r4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v4 <= 1'b0;
      r4 <= '0;
    end else if (adv) begin
      v4 <= v3;
      r4 <= freeze(r3, coeff_t'(Q));
    end
  end

  assign ov    = v4;
  assign r_out = r4;
  assign busy  = v1 | redc_busy | v4;
`else
  assign ov    = v3;
  assign r_out = r3;
  assign busy  = v1 | redc_busy;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (ov && bus.out_ready) begin
      if (idx == IW'(N - 1)) begin
        idx <= '0;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  assign bus.out_valid = ov;
  assign bus.out_data  = WIDTH'(r_out);
  assign bus.out_last  = ov && (idx == IW'(N - 1));

endmodule

// File: doc/mont_encode_pipe.md
# mont_encode_pipe

Streaming converter that moves Dilithium coefficients into the Montgomery domain (x -> x·2^32 mod q) ahead of the butterfly unit. It pairs with the existing Montgomery reduction, which leaves that domain. Internally it multiplies by R² mod q and then applies a pipelined Montgomery reduction. It has a valid/ready interface with full backpressure and frames each polynomial of N coefficients with a last flag.

## Interface
Parameters:
- `Q` — 8380417 — modulus q
- `QINV` — 58728449 — q⁻¹ mod 2^32
- `R2` — 2365951 — 2^64 mod q
- `N` — 256 — coefficients per polynomial
- `WIDTH` — 32 — coefficient width (signed)

Ports (clock and reset first). One clock; reset is asynchronous and active-low.
- `clk` — in — 1 — clock
- `rst_n` — in — 1 — asynchronous active-low reset
- `in_valid` — in — 1 — input coefficient valid
- `in_ready` — out — 1 — block accepts input
- `in_data` — in — WIDTH — signed coefficient; must satisfy |x| < 2^31
- `out_valid` — out — 1 — result valid
- `out_ready` — in — 1 — downstream accepts
- `out_data` — out — WIDTH — signed result ≡ x·2^32 mod q
- `out_last` — out — 1 — high on the N-th coefficient of each polynomial
- `busy` — out — 1 — any pipeline stage holds valid data

## Operation
- S1 computes the 64-bit signed product p = in_data·R2.
- S2 computes t = signed low 32 bits of (p[31:0]·QINV). It carries p forward.
- S3 computes r = (p − t·Q) >> 32 (arithmetic shift). Then r = p[63:32] − (t·Q)[63:32], and the low 32 bits cancel exactly.
- Result range without freeze: −q < r < q.
- Output coefficient counter `idx` (0..N−1):
  - increments on every output handshake (out_valid && out_ready);
  - `out_last` = (idx == N−1) && out_valid;
  - idx wraps to 0 after N−1.
- Each stage has a valid bit. The pipeline advances as a unit when `adv = !out_valid || out_ready`.
- `in_ready = adv`.
- When adv is low, all stage registers and valid bits hold.
- On reset, all of the following are 0: valid bits, idx, out_valid, out_data, out_last, busy. Data registers are also cleared.
- Asserting `rst_n` low mid-stream drops all in-flight coefficients immediately. No partial polynomial is reported, and idx restarts at 0.

## Timing
- Latency: 3 cycles from input handshake to out_valid without freeze, 4 with freeze, when no stall occurs.
- Throughput: 1 coefficient per cycle while out_ready = 1.
- Input handshake: in_valid && in_ready on a rising edge.
- out_data/out_valid/out_last are registered outputs. They are stable while out_valid && !out_ready.
- in_ready is combinational from out_ready.
- Simultaneous input and output handshake in the same cycle is legal and is the steady state.
- Bubbles (in_valid = 0) propagate as invalid stages. They do not advance idx.

## Configuration
- Macro: `MONT_ENCODE_FREEZE_EN`.
- Defined:
  - adds stage S4, which maps r to canonical form: if r < 0 then r + Q;
  - out_data ∈ [0, q), unsigned-valued in the signed port;
  - latency 4.
- Undefined:
  - no S4; out_data ∈ (−q, q);
  - latency 3.

## Structure
- Shared package `dilithium_pkg`:
  - Q, QINV, R2, MONT (2^32 mod q = 4193792), N;
  - the coefficient type (signed 32-bit);
  - the 64-bit product type.
- Sub-module `mont_redc_stage`: two-register Montgomery reduction (S2–S3) with an enable input. It is instantiated once. Keep it separate from the existing combinational reducer so the butterfly is untouched.
- The top level holds S1, the optional S4, the valid/stall control and the idx counter.

## Test plan
- Freeze on, inputs 0, 1, 8380416, 8380417 back-to-back, out_ready = 1 → outputs 0, 4193792, 4186625, 0 on cycles 4–7 after the first handshake.
- Freeze off, input 1 → out_data ≡ 4193792 (mod q) and |out_data| < q. Repeat with 10 000 random |x| < 2^31 against a reference model.
- Stream 2N coefficients → out_last high exactly on output indices 255 and 511. idx wraps to 0.
- Hold out_ready = 0 for 5 cycles with the pipeline full:
  - out_data is stable and in_ready = 0;
  - after release, outputs resume in order with no loss or duplication.
- Insert random in_valid bubbles and random out_ready → the output sequence equals the input sequence, mapped, and in order.
- Pull rst_n low for 1 cycle with 3 coefficients in flight:
  - out_valid, busy and out_last go to 0 asynchronously;
  - the next polynomial's first output has idx 0.
